// File: rtl/buffer_serializer.sv
// ============================================================================
// Module      : buffer_serializer
// Description : Parallel-in, serial-out transmitter for the register buffer.
//               Loads one WIDTH-bit word over valid/ready, streams it one bit
//               per accepted cycle and marks the final bit with ser_last.
//               Define LSB_FIRST_EN to stream bit 0 first (default: MSB first).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buffer_serializer #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready
);

    localparam int unsigned c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   shreg_q,     shreg_d;
    logic [c_cnt_w-1:0] cnt_q,       cnt_d;
    logic               ser_valid_q, ser_valid_d;
    logic               ser_last_q,  ser_last_d;

    logic w_load_xfer;
    logic w_ser_xfer;

    // A new word may enter either from IDLE or on the final bit's transfer.
    assign load_ready  = (state_q == IDLE) | (ser_valid_q & ser_last_q & ser_ready);
    assign w_load_xfer = load_valid & load_ready;
    assign w_ser_xfer  = ser_valid_q & ser_ready;

    // The outgoing bit is the head flop of the shift register itself.
`ifdef LSB_FIRST_EN
    assign ser_out = shreg_q[0];
`else
    assign ser_out = shreg_q[WIDTH-1];
`endif
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        ser_valid_d = ser_valid_q;
        ser_last_d  = ser_last_q;

        if (w_load_xfer) begin
            state_d     = SHIFT;
            shreg_d     = load_data;
            cnt_d       = '0;
            ser_valid_d = 1'b1;
            ser_last_d  = 1'b0;
        end else if (w_ser_xfer) begin
            if (ser_last_q) begin
                state_d     = IDLE;
                ser_valid_d = 1'b0;
                ser_last_d  = 1'b0;
            end else begin
`ifdef LSB_FIRST_EN
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
`else
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`endif
                cnt_d      = cnt_q + c_cnt_w'(1);
                ser_last_d = (cnt_d == c_cnt_max);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_buffer_serializer.sv
// ============================================================================
// Module      : tb_buffer_serializer
// Description : Directed self-checking bench for buffer_serializer (WIDTH=128).
//               Bit order follows LSB_FIRST_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buffer_serializer;

    localparam int unsigned WIDTH = 128;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             ser_ready;

    int checks = 0;
    int fails  = 0;

    buffer_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .ser_ready  (ser_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream position k carries this word bit.
    function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int k);
`ifdef LSB_FIRST_EN
        return w[k];
`else
        return w[WIDTH-1-k];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [WIDTH-1:0] w);
        load_valid = 1'b1;
        load_data  = w;
        check("load_ready_idle", 32'(load_ready), 32'd1);
        tick();
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    // Called in the cycle holding bit 0. Optional stalls at bit 64 and the last
    // bit, a blocked load attempt at bit blk_at, and a chained next word.
    task automatic run_word(input logic [WIDTH-1:0] w, input bit chain,
                            input logic [WIDTH-1:0] nxt, input int s64,
                            input int slast, input int blk_at);
        int cyc;
        int ns;
        cyc = 0;
        if (chain) begin
            load_valid = 1'b1;
            load_data  = nxt;
        end
        for (int k = 0; k < WIDTH; k++) begin
            ns = (k == 64) ? s64 : ((k == WIDTH - 1) ? slast : 0);
            for (int s = 0; s < ns; s++) begin
                ser_ready = 1'b0;
                #1;
                check("stall_valid", 32'(ser_valid), 32'd1);
                check("stall_out",   32'(ser_out),   32'(exp_bit(w, k)));
                check("stall_last",  32'(ser_last),  32'(k == WIDTH - 1));
                check("stall_ready", 32'(load_ready), 32'd0);
                tick();
                cyc++;
            end
            ser_ready = 1'b1;
            if (k == blk_at) begin
                load_valid = 1'b1;
                load_data  = ~w;
            end
            #1;
            check("ser_valid",  32'(ser_valid),  32'd1);
            check("ser_out",    32'(ser_out),    32'(exp_bit(w, k)));
            check("ser_last",   32'(ser_last),   32'(k == WIDTH - 1));
            check("load_ready", 32'(load_ready), 32'(k == WIDTH - 1));
            tick();
            cyc++;
            if (k == blk_at) begin
                load_valid = 1'b0;
                load_data  = '0;
            end
        end
        load_valid = 1'b0;
        check("word_cycles", 32'(cyc), 32'(WIDTH + s64 + slast));
        if (chain) begin
            check("chain_valid", 32'(ser_valid), 32'd1);
            check("chain_last",  32'(ser_last),  32'd0);
            check("chain_first", 32'(ser_out),   32'(exp_bit(nxt, 0)));
        end else begin
            check("end_valid", 32'(ser_valid),  32'd0);
            check("end_last",  32'(ser_last),   32'd0);
            check("end_ready", 32'(load_ready), 32'd1);
        end
    endtask

    localparam logic [WIDTH-1:0] W_ENDS = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [WIDTH-1:0] W_3    = 128'h3;
    localparam logic [WIDTH-1:0] W_A    = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F0E1_D2C3;
    localparam logic [WIDTH-1:0] W_B    = 128'h1357_9BDF_2468_ACE0_5A5A_A5A5_0F0F_F0F0;
    localparam logic [WIDTH-1:0] W_C    = 128'hC001_D00D_8421_1248_7777_0000_FFFF_1234;

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        ser_ready  = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(ser_valid),  32'd0);
        check("rst_last",  32'(ser_last),   32'd0);
        check("rst_out",   32'(ser_out),    32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single word with both end bits set.
        load_word(W_ENDS);
        run_word(W_ENDS, 1'b0, '0, 0, 0, -1);
        tick();

        // Bit-order probe.
        load_word(W_3);
        run_word(W_3, 1'b0, '0, 0, 0, -1);

        // Back-to-back with load_valid held high.
        load_word(W_A);
        run_word(W_A, 1'b1, W_B, 0, 0, -1);
        run_word(W_B, 1'b0, '0, 0, 0, -1);

        // Backpressure: 5 stalls at bit 64, 3 while ser_last is high.
        load_word(W_C);
        run_word(W_C, 1'b0, '0, 5, 3, -1);

        // Load attempt mid-word is refused and the word is unaffected.
        load_word(W_A);
        run_word(W_A, 1'b0, '0, 0, 0, 10);

        // Asynchronous reset mid-word, then a fresh word from its first bit.
        load_word(W_B);
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ser_valid),  32'd0);
        check("arst_last",  32'(ser_last),   32'd0);
        check("arst_out",   32'(ser_out),    32'd0);
        check("arst_ready", 32'(load_ready), 32'd1);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        load_word(W_3);
        run_word(W_3, 1'b0, '0, 0, 0, -1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

`default_nettype wire
